// File: rtl/gate_nand_arbiter.sv
// Round-robin arbiter sharing one gate_nand among REQ valid/ready requesters.
// Registered operand drives the shared gate; result returned with requester id.

module gate_nand #(
    parameter int          BEHAVIORAL = 1,
    parameter int unsigned WAY        = 2,
    parameter int unsigned WIRE       = 1
) (
    input  logic [WAY*WIRE-1:0] in,
    output logic [WIRE-1:0]     out
);

    if (BEHAVIORAL != 0) begin : g_beh
        always_comb begin
            logic acc;
            out = '1;
            for (int unsigned w = 0; w < WIRE; w++) begin
                acc = 1'b1;
                for (int unsigned k = 0; k < WAY; k++) begin
                    acc = acc & in[k*WIRE + w];
                end
                out[w] = ~acc;
            end
        end
    end else begin : g_struct
        for (genvar w = 0; w < WIRE; w++) begin : g_bit
            logic [WAY-1:0] chain;
            assign chain[0] = in[w];
            for (genvar k = 1; k < WAY; k++) begin : g_and
                assign chain[k] = chain[k-1] & in[k*WIRE + w];
            end
            assign out[w] = ~chain[WAY-1];
        end
    end

endmodule

module gate_nand_arbiter #(
    parameter int          BEHAVIORAL = 1,
    parameter int unsigned WAY        = 2,
    parameter int unsigned WIRE       = 1,
    parameter int unsigned REQ        = 4,
    localparam int unsigned IDW       = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [REQ-1:0]          req_valid,
    output logic [REQ-1:0]          req_ready,
    input  logic [REQ*WAY*WIRE-1:0] req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIRE-1:0]         rsp_data
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]          state;
    logic [WAY*WIRE-1:0] opr;
    logic [IDW-1:0]      id_q;
    logic [IDW-1:0]      ptr;

    logic                gnt_any;
    logic [IDW-1:0]      gnt_id;
    logic [IDW-1:0]      ptr_next;
    logic [WAY*WIRE-1:0] sel_data;
    logic                can_accept;
    logic                accept;

    // First valid requester at or after ptr, wrapping modulo REQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int unsigned off = 0; off < REQ; off++) begin
            idx = (int'(ptr) + off) % REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign sel_data   = req_data[gnt_id*WAY*WIRE +: WAY*WIRE];
    assign ptr_next   = (gnt_id == IDW'(REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) | (rsp_valid & rsp_ready);
    // Gated by reset so nothing appears accepted while the slot is being cleared.
    assign accept     = gnt_any & can_accept & ~reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            opr   <= '0;
            id_q  <= '0;
            ptr   <= '0;
        end else if (accept) begin
            state <= FULL;
            opr   <= sel_data;
            id_q  <= gnt_id;
            ptr   <= ptr_next;
        end else if (rsp_valid && rsp_ready) begin
            state <= EMPTY;
        end
    end

    assign rsp_id = id_q;

    gate_nand #(
        .BEHAVIORAL(BEHAVIORAL),
        .WAY       (WAY),
        .WIRE      (WIRE)
    ) u_gate (
        .in (opr),
        .out(rsp_data)
    );

endmodule

// File: tb/tb_gate_nand_arbiter.sv
// Directed bench for gate_nand_arbiter: reset, single/back-to-back requests,
// round robin, backpressure, pointer skip, wide single-requester variant.

module tb_gate_nand_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic [0:0] rsp_data;

    logic       w_req_valid;
    logic       w_req_ready;
    logic [5:0] w_req_data;
    logic       w_rsp_valid;
    logic       w_rsp_ready;
    logic [0:0] w_rsp_id;
    logic [1:0] w_rsp_data;
    logic [5:0] w_last;
    logic [1:0] ref_out;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    gate_nand_arbiter #(
        .BEHAVIORAL(1),
        .WAY       (2),
        .WIRE      (1),
        .REQ       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data)
    );

    gate_nand_arbiter #(
        .BEHAVIORAL(1),
        .WAY       (3),
        .WIRE      (2),
        .REQ       (1)
    ) dut_wide (
        .clk      (clk),
        .reset    (reset),
        .req_valid(w_req_valid),
        .req_ready(w_req_ready),
        .req_data (w_req_data),
        .rsp_valid(w_rsp_valid),
        .rsp_ready(w_rsp_ready),
        .rsp_id   (w_rsp_id),
        .rsp_data (w_rsp_data)
    );

    gate_nand #(
        .BEHAVIORAL(0),
        .WAY       (3),
        .WIRE      (2)
    ) u_ref (
        .in (w_last),
        .out(ref_out)
    );

    function automatic logic [1:0] nand3x2(input logic [5:0] d);
        logic [1:0] r;
        for (int w = 0; w < 2; w++) begin
            r[w] = ~(d[w] & d[2 + w] & d[4 + w]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // slice i nand results for req_data = 8'b11_10_01_00
    logic [3:0] rr_nand;

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        w_req_valid = 1'b0;
        w_req_data  = '0;
        w_rsp_ready = 1'b1;
        w_last      = '0;
        rr_nand     = 4'b0111;

        #2;
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id",    32'(rsp_id),    32'h0);
        chk("rst_data",  32'(rsp_data),  32'h1);
        chk("rst_ready", 32'(req_ready), 32'h0);
        tick;
        reset = 1'b0;

        // single request, operand 11 -> 0
        req_valid = 4'b0001;
        req_data  = 8'b0000_0011;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h1);
        tick;
        req_valid = 4'b0000;
        #1;
        chk("t2_valid",   32'(rsp_valid), 32'h1);
        chk("t2_id",      32'(rsp_id),    32'h0);
        chk("t2_data",    32'(rsp_data),  32'h0);
        chk("t2_ready_0", 32'(req_ready), 32'h0);
        rsp_ready = 1'b1;
        tick;
        chk("t2_empty", 32'(rsp_valid), 32'h0);

        // operand 10 -> 1 (ptr now 1, wraps to 0)
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_data  = 8'b0000_0010;
        #1;
        chk("t2b_ready", 32'(req_ready), 32'h1);
        tick;
        req_valid = 4'b0000;
        #1;
        chk("t2b_id",   32'(rsp_id),   32'h0);
        chk("t2b_data", 32'(rsp_data), 32'h1);
        rsp_ready = 1'b1;
        tick;

        // get FULL with req 2 then reset asynchronously
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        req_data  = 8'b0011_0000;
        tick;
        chk("t1_full", 32'(rsp_valid), 32'h1);
        chk("t1_id",   32'(rsp_id),    32'h2);
        chk("t1_data", 32'(rsp_data),  32'h0);
        reset = 1'b1;
        #1;
        chk("t1_valid", 32'(rsp_valid), 32'h0);
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_data1", 32'(rsp_data),  32'h1);
        chk("t1_id0",   32'(rsp_id),    32'h0);
        tick;
        reset = 1'b0;

        // round robin from ptr 0, no bubbles
        req_valid = 4'b1111;
        req_data  = 8'b11_10_01_00;
        rsp_ready = 1'b1;
        #1;
        chk("t3_ready0", 32'(req_ready), 32'h1);
        tick;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_valid", 32'(rsp_valid), 32'h1);
            chk("t3_id",    32'(rsp_id),    32'(k - 1));
            chk("t3_data",  32'(rr_nand[k - 1]), 32'(rsp_data));
            chk("t3_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick;
        end
        chk("t3_id_wrap", 32'(rsp_id), 32'h0);

        // backpressure: slot holds req 0 result, ptr = 1
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_ready", 32'(req_ready), 32'h0);
            chk("t4_valid", 32'(rsp_valid), 32'h1);
            chk("t4_id",    32'(rsp_id),    32'h0);
            chk("t4_data",  32'(rsp_data),  32'h1);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_release", 32'(req_ready), 32'h2);
        tick;
        chk("t4_next_id", 32'(rsp_id),    32'h1);
        chk("t4_next_v",  32'(rsp_valid), 32'h1);

        // pointer skip: ptr = 2, requests 3 and 0
        req_valid = 4'b1001;
        #1;
        chk("t5_g3", 32'(req_ready), 32'h8);
        tick;
        chk("t5_id3", 32'(rsp_id),    32'h3);
        chk("t5_g0",  32'(req_ready), 32'h1);
        tick;
        chk("t5_id0", 32'(rsp_id), 32'h0);
        req_valid = 4'b1111;
        #1;
        chk("t5_ptr1", 32'(req_ready), 32'h2);
        tick;
        req_valid = 4'b0000;
        tick;
        chk("t5_drain", 32'(rsp_valid), 32'h0);

        // wide variant, REQ = 1
        w_req_valid = 1'b1;
        w_req_data  = 6'b11_11_01;
        #1;
        chk("t6_ready", 32'(w_req_ready), 32'h1);
        tick;
        chk("t6_valid", 32'(w_rsp_valid), 32'h1);
        chk("t6_id",    32'(w_rsp_id),    32'h0);
        chk("t6_data",  32'(w_rsp_data),  32'h2);
        for (int k = 0; k < 1000; k++) begin
            logic [5:0] d;
            d          = 6'($urandom_range(0, 63));
            w_req_data = d;
            tick;
            w_last = d;
            #1;
            chk("t6_model", 32'(w_rsp_data), 32'(nand3x2(d)));
            chk("t6_ref",   32'(w_rsp_data), 32'(ref_out));
        end
        w_req_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
